hex_display_ctrl: RTL and testbench

//  Parametrised successor to the DE10-Lite switch-to-HEX display driver. Latches an IN_W-bit value on a

---
 rtl/hex_display_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_hex_display_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// Hex / decimal seven-segment display controller.
// A load latches a value; hex conversion commits in one cycle, decimal conversion runs a
// sequential double-dabble first. Adds leading-zero blanking, overflow dashes and blinking.
module hex_display_ctrl #(
  parameter int unsigned IN_W      = 10,
  parameter int unsigned DIGITS    = 6,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_W-1:0]       in_val,
  input  logic                  load,
  input  logic                  dec_mode,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [8*DIGITS-1:0]   hex_out,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  // ceil(w * log10(2)) using a fixed-point approximation of log10(2)
  function automatic int unsigned dec_digits(input int unsigned w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  localparam int unsigned BcdN   = dec_digits(IN_W) + 1;
  localparam int unsigned BcdW   = 4 * BcdN;
  localparam int unsigned HexN   = (IN_W + 3) / 4;
  localparam int unsigned SrcN   = (BcdN > HexN) ? BcdN : HexN;
  localparam int unsigned AllN   = (SrcN > DIGITS) ? SrcN : DIGITS;
  localparam int unsigned AllW   = 4 * AllN;
  localparam int unsigned ScntW  = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int unsigned BlkW   = $clog2(BLINK_DIV);

  localparam logic [7:0] SegBlank = 8'hFF;
  localparam logic [7:0] SegDash  = 8'hBF;

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e                state_q, state_d;
  logic [IN_W-1:0]       val_q, val_d;
  logic [BcdW-1:0]       bcd_q, bcd_d, bcd_adj;
  logic                  dec_q, dec_d;
  logic                  blz_q, blz_d;
  logic [ScntW-1:0]      scnt_q, scnt_d;
  logic [8*DIGITS-1:0]   hex_q, hex_d, commit_hex;
  logic                  ovf_q, ovf_d, commit_ovf;
  logic                  done_q, done_d;
  logic [BlkW-1:0]       blk_cnt_q, blk_cnt_d;
  logic                  blink_on_q, blink_on_d;
  logic [AllW-1:0]       src;
  int unsigned           msd;

  // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one nibble
  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < BcdN; i++) begin
      if (bcd_q[4*i+:4] >= 4'd5) begin
        bcd_adj[4*i+:4] = bcd_q[4*i+:4] + 4'd3;
      end
    end
  end

  // Build the committed digit pattern from the BCD or raw value
  always_comb begin
    src        = dec_q ? AllW'(bcd_q) : AllW'(val_q);
    commit_ovf = 1'b0;
    msd        = 0;
    commit_hex = '1;
    for (int unsigned i = DIGITS; i < AllN; i++) begin
      if (src[4*i+:4] != 4'd0) commit_ovf = 1'b1;
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (src[4*i+:4] != 4'd0) msd = i;
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (commit_ovf) begin
        commit_hex[8*i+:8] = SegDash;
      end else if (blz_q && (i > msd)) begin
        commit_hex[8*i+:8] = SegBlank;
      end else begin
        commit_hex[8*i+:8] = seg7(src[4*i+:4]);
      end
    end
  end

  // Conversion FSM next-state and datapath
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    bcd_d   = bcd_q;
    dec_d   = dec_q;
    blz_d   = blz_q;
    scnt_d  = scnt_q;
    hex_d   = hex_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          val_d   = in_val;
          dec_d   = dec_mode;
          blz_d   = blank_lz;
          bcd_d   = '0;
          scnt_d  = '0;
          state_d = dec_mode ? StShift : StCommit;
        end
      end
      StShift: begin
        bcd_d  = {bcd_adj[BcdW-2:0], val_q[IN_W-1]};
        val_d  = val_q << 1;
        scnt_d = scnt_q + 1'b1;
        if (scnt_q == ScntW'(IN_W - 1)) state_d = StCommit;
      end
      StCommit: begin
        hex_d   = commit_hex;
        ovf_d   = commit_ovf;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Blink timer: phase toggles every BLINK_DIV enabled cycles, held ON when disabled
  always_comb begin
    blk_cnt_d  = blk_cnt_q;
    blink_on_d = blink_on_q;
    if (!blink_en) begin
      blk_cnt_d  = '0;
      blink_on_d = 1'b1;
    end else if (blk_cnt_q == BlkW'(BLINK_DIV - 1)) begin
      blk_cnt_d  = '0;
      blink_on_d = ~blink_on_q;
    end else begin
      blk_cnt_d = blk_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      val_q      <= '0;
      bcd_q      <= '0;
      dec_q      <= 1'b0;
      blz_q      <= 1'b0;
      scnt_q     <= '0;
      hex_q      <= '1;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      blk_cnt_q  <= '0;
      blink_on_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      bcd_q      <= bcd_d;
      dec_q      <= dec_d;
      blz_q      <= blz_d;
      scnt_q     <= scnt_d;
      hex_q      <= hex_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      blk_cnt_q  <= blk_cnt_d;
      blink_on_q <= blink_on_d;
    end
  end

  // Blink phase OFF blanks the display without touching the committed pattern
  always_comb begin
    hex_out = blink_on_q ? hex_q : '1;
    busy    = (state_q != StIdle);
    done    = done_q;
    ovf     = ovf_q;
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench: two instances (6 and 3 digits) share stimulus; table vectors,
// corner-case sequences and random loads checked against an arithmetic reference model.
module tb_hex_display_ctrl;

  localparam int unsigned InW = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  in_val = '0;
  logic        load = 1'b0;
  logic        dec_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [47:0] hex_a;
  logic [23:0] hex_b;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;

  int n_checks = 0;
  int n_err = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  hex_display_ctrl #(.IN_W(InW), .DIGITS(6), .BLINK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .in_val(in_val), .load(load), .dec_mode(dec_mode),
    .blank_lz(blank_lz), .blink_en(blink_en), .hex_out(hex_a), .busy(busy_a),
    .done(done_a), .ovf(ovf_a)
  );

  hex_display_ctrl #(.IN_W(InW), .DIGITS(3), .BLINK_DIV(4)) dut_b (
    .clk(clk), .reset(reset), .in_val(in_val), .load(load), .dec_mode(dec_mode),
    .blank_lz(blank_lz), .blink_en(blink_en), .hex_out(hex_b), .busy(busy_b),
    .done(done_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [9:0]  v;
    bit          dec;
    bit          blz;
    logic [47:0] ea;
    bit          oa;
    logic [23:0] eb;
    bit          ob;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: digits by repeated division in base 10/16
  function automatic logic [47:0] model(input int unsigned v, input bit dec, input bit blz,
                                        input int unsigned nd, output bit o);
    int unsigned base;
    int unsigned t;
    int unsigned sig;
    int unsigned dg [8];
    logic [47:0] r;
    base = dec ? 10 : 16;
    o    = (v >= base ** nd);
    t    = v;
    for (int i = 0; i < 8; i++) begin
      dg[i] = t % base;
      t     = t / base;
    end
    sig = 1;
    for (int i = 0; i < 8; i++) if (dg[i] != 0) sig = i + 1;
    r = '1;
    for (int i = 0; i < int'(nd); i++) begin
      if (o) r[8*i+:8] = 8'hBF;
      else if (blz && i >= int'(sig)) r[8*i+:8] = 8'hFF;
      else r[8*i+:8] = seg_tab[dg[i]];
    end
    return r;
  endfunction

  // Issue one load and wait (bounded) for done; checks timing and busy behaviour.
  // If ign_at > 0, a second load with value 5 is pulsed ign_at cycles after acceptance.
  task automatic run_load(input logic [9:0] v, input bit dec, input bit blz,
                          input int ign_at);
    int lat;
    bit bsy_ok;
    @(negedge clk);
    in_val   = v;
    dec_mode = dec;
    blank_lz = blz;
    load     = 1'b1;
    @(posedge clk);
    #1;
    load   = 1'b0;
    lat    = 0;
    bsy_ok = busy_a && busy_b;
    for (int n = 1; n <= 40; n++) begin
      if (ign_at > 0 && n - 1 == ign_at) begin
        in_val = 10'd5;
        load   = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done_a) begin
        lat = n;
        break;
      end
      if (!busy_a || !busy_b) bsy_ok = 1'b0;
    end
    load = 1'b0;
    chk("latency", lat, dec ? InW + 1 : 1);
    chk("busy_during", bsy_ok, 1);
    chk("busy_at_done", {busy_a, busy_b}, 2'b00);
    chk("done_b_sync", done_b, 1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {done_a, done_b}, 2'b00);
  endtask

  task automatic chk_out(input string name, input logic [47:0] ea, input bit oa,
                         input logic [23:0] eb, input bit ob);
    chk({name, "_hex_a"}, hex_a, ea);
    chk({name, "_ovf_a"}, ovf_a, oa);
    chk({name, "_hex_b"}, hex_b, eb);
    chk({name, "_ovf_b"}, ovf_b, ob);
  endtask

  initial begin
    logic [47:0] ma;
    logic [47:0] mb;
    bit          moa;
    bit          mob;
    bit          seen;
    bit          on;

    vt[0] = '{10'h007, 0, 0, 48'hC0C0C0C0C0F8, 0, 24'hC0C0F8, 0};
    vt[1] = '{10'd1023, 1, 1, 48'hFFFFF9C0A4B0, 0, 24'hBFBFBF, 1};
    vt[2] = '{10'd0, 1, 1, 48'hFFFFFFFFFFC0, 0, 24'hFFFFC0, 0};
    vt[3] = '{10'd7, 1, 1, 48'hFFFFFFFFFFF8, 0, 24'hFFFFF8, 0};
    vt[4] = '{10'd99, 1, 0, 48'hC0C0C0C09090, 0, 24'hC09090, 0};
    vt[5] = '{10'h3A5, 0, 1, 48'hFFFFFFB08892, 0, 24'hB08892, 0};
    vt[6] = '{10'h000, 0, 0, 48'hC0C0C0C0C0C0, 0, 24'hC0C0C0, 0};
    vt[7] = '{10'd1000, 1, 0, 48'hC0C0F9C0C0C0, 0, 24'hBFBFBF, 1};
    vt[8] = '{10'h2AF, 0, 1, 48'hFFFFFFA4888E, 0, 24'hA4888E, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_out("reset", 48'hFFFFFFFFFFFF, 0, 24'hFFFFFF, 0);
    chk("reset_busy_done", {busy_a, done_a, busy_b, done_b}, 4'b0000);

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      run_load(vt[i].v, vt[i].dec, vt[i].blz, 0);
      chk_out("vec", vt[i].ea, vt[i].oa, vt[i].eb, vt[i].ob);
    end

    // Load while busy is ignored; the original value is committed, a later load shows 5
    run_load(10'd1023, 1, 1, 3);
    chk_out("ignored_load", 48'hFFFFF9C0A4B0, 0, 24'hBFBFBF, 1);
    run_load(10'd5, 1, 1, 0);
    chk_out("after_ignore", 48'hFFFFFFFFFF92, 0, 24'hFFFF92, 0);

    // Reset mid-conversion aborts: blank display, idle, no done
    @(negedge clk);
    in_val   = 10'd1023;
    dec_mode = 1'b1;
    load     = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_out("mid_reset", 48'hFFFFFFFFFFFF, 0, 24'hFFFFFF, 0);
    chk("mid_reset_busy", {busy_a, busy_b}, 2'b00);
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (done_a || done_b || busy_a) seen = 1'b1;
    end
    chk("mid_reset_no_done", seen, 0);

    // Blink: 4 cycles on, 4 cycles blank, value retained
    run_load(10'd99, 1, 0, 0);
    blink_en = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(posedge clk);
      #1;
      on = (((j + 1) / 4) % 2) == 0;
      chk("blink_a", hex_a, on ? 48'hC0C0C0C09090 : 48'hFFFFFFFFFFFF);
      chk("blink_b", hex_b, on ? 24'hC09090 : 24'hFFFFFF);
    end
    blink_en = 1'b0;
    @(posedge clk);
    #1;
    chk_out("blink_off", 48'hC0C0C0C09090, 0, 24'hC09090, 0);

    // Random loads against the reference model
    for (int r = 0; r < 25; r++) begin
      logic [9:0] v;
      bit d;
      bit b;
      v  = 10'($urandom_range(0, 1023));
      d  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      ma = model(v, d, b, 6, moa);
      mb = model(v, d, b, 3, mob);
      run_load(v, d, b, 0);
      chk_out("rand", ma, moa, mb[23:0], mob);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
